serial_subtractor: RTL and testbench



---
 rtl/serial_arith_pkg.sv | 24 ++
 rtl/serial_subtractor_if.sv | 31 +++
 rtl/full_subtractor.sv | 18 +
 rtl/serial_subtractor.sv | 128 ++++++++++++
 tb/tb_serial_subtractor.sv | 151 +++++++++++++++
 5 files changed

// File: rtl/serial_arith_pkg.sv
// ============================================================================
// serial_arith_pkg : shared types and constants for the bit-serial arithmetic units
// Revision: 1.0
// ============================================================================
`default_nettype none

package serial_arith_pkg;

  localparam int c_default_width = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // The counter must hold values up to WIDTH.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/serial_subtractor_if.sv
// ============================================================================
// serial_subtractor_if : start/busy/done handshake and result bus of the serial subtractor
// Revision: 1.0
// ============================================================================
`default_nettype none

interface serial_subtractor_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] data_a;
  logic [WIDTH-1:0] data_b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] out;
  logic             bout;
  logic [WIDTH:0]   acc;
  logic             ovf;

  modport master (
    output start, data_a, data_b,
    input  busy, done, out, bout, acc, ovf
  );

  modport slave (
    input  start, data_a, data_b,
    output busy, done, out, bout, acc, ovf
  );
endinterface

`default_nettype wire

// File: rtl/full_subtractor.sv
// ============================================================================
// full_subtractor : single-bit combinational difference/borrow cell
// Revision: 1.0
// ============================================================================
`default_nettype none

module full_subtractor (
  input  wire logic a,
  input  wire logic b,
  input  wire logic bin,
  output logic      d,
  output logic      bout
);
  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);
endmodule

`default_nettype wire

// File: rtl/serial_subtractor.sv
// ============================================================================
// serial_subtractor : LSB-first bit-serial data_a - data_b, one bit per clock.
// Optional macro SERIAL_SUB_OVF_EN enables the registered signed-overflow flag.
// Revision: 1.0
// ============================================================================
`default_nettype none

module serial_subtractor
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = c_default_width
) (
  input  wire logic          clk,
  input  wire logic          reset,
  serial_subtractor_if.slave bus
);
  localparam int c_cnt_w = cnt_width(WIDTH);

  state_t             r_state;
  state_t             w_state_next;
  logic [WIDTH-1:0]   r_sa;
  logic [WIDTH-1:0]   r_sb;
  logic [WIDTH-1:0]   r_res;
  logic               r_br;
  logic [c_cnt_w-1:0] r_cnt;
  logic [WIDTH-1:0]   r_out;
  logic               r_bout;
  logic [WIDTH:0]     r_acc;
  logic               w_d;
  logic               w_bout;
  logic               w_last;
  logic [WIDTH-1:0]   w_res_next;

  full_subtractor u_cell (
    .a    (r_sa[0]),
    .b    (r_sb[0]),
    .bin  (r_br),
    .d    (w_d),
    .bout (w_bout)
  );

  assign w_last     = (r_cnt == c_cnt_w'(WIDTH - 1));
  assign w_res_next = {w_d, r_res[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (bus.start) w_state_next = SHIFT;
      SHIFT:   if (w_last)    w_state_next = DONE;
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sa   <= '0;
      r_sb   <= '0;
      r_res  <= '0;
      r_br   <= 1'b0;
      r_cnt  <= '0;
      r_out  <= '0;
      r_bout <= 1'b0;
      r_acc  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_sa  <= bus.data_a;
            r_sb  <= bus.data_b;
            r_br  <= 1'b0;
            r_cnt <= '0;
          end
        end
        SHIFT: begin
          r_sa  <= r_sa >> 1;
          r_sb  <= r_sb >> 1;
          r_res <= w_res_next;
          r_br  <= w_bout;
          r_cnt <= r_cnt + 1'b1;
          // Published results only move on the final bit.
          if (w_last) begin
            r_out  <= w_res_next;
            r_bout <= w_bout;
            r_acc  <= {w_bout, w_res_next};
          end
        end
        default: ;
      endcase
    end
  end

`ifdef SERIAL_SUB_OVF_EN
  logic r_a_msb;
  logic r_b_msb;
  logic r_ovf;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_a_msb <= 1'b0;
      r_b_msb <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (r_state == IDLE && bus.start) begin
      r_a_msb <= bus.data_a[WIDTH-1];
      r_b_msb <= bus.data_b[WIDTH-1];
    end else if (r_state == SHIFT && w_last) begin
      r_ovf <= (r_a_msb != r_b_msb) && (w_res_next[WIDTH-1] != r_a_msb);
    end
  end

  assign bus.ovf = r_ovf;
`else
  assign bus.ovf = 1'b0;
`endif

  assign bus.busy = (r_state != IDLE);
  assign bus.done = (r_state == DONE);
  assign bus.out  = r_out;
  assign bus.bout = r_bout;
  assign bus.acc  = r_acc;
endmodule

`default_nettype wire

// File: tb/tb_serial_subtractor.sv
// ============================================================================
// tb_serial_subtractor : directed scoreboard bench for serial_subtractor (WIDTH=4)
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_serial_subtractor;
  localparam int WIDTH = 4;
`ifdef SERIAL_SUB_OVF_EN
  localparam bit c_ovf_en = 1'b1;
`else
  localparam bit c_ovf_en = 1'b0;
`endif

  typedef struct {
    logic [WIDTH-1:0] out;
    logic             bout;
    logic [WIDTH:0]   acc;
    logic             ovf;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_tests = 0;
  int   n_fail = 0;
  exp_t q[$];
  logic [WIDTH-1:0] last_out = '0;

  serial_subtractor_if #(.WIDTH(WIDTH)) bus ();

  serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Monitor: every done pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (bus.done === 1'b1) begin
      if (q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("out",  32'(bus.out),  32'(e.out));
        check("bout", 32'(bus.bout), 32'(e.bout));
        check("acc",  32'(bus.acc),  32'(e.acc));
        check("ovf",  32'(bus.ovf),  32'(e.ovf));
      end
    end
  end

  task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic [WIDTH-1:0] e_out, input logic e_bout,
                        input logic [WIDTH:0] e_acc, input logic e_ovf);
    int n;
    @(negedge clk);
    bus.start  = 1'b1;
    bus.data_a = a;
    bus.data_b = b;
    q.push_back('{out: e_out, bout: e_bout, acc: e_acc, ovf: e_ovf & c_ovf_en});
    @(posedge clk);
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        bus.start = 1'b0;
        check("hold_out", 32'(bus.out), 32'(last_out));
      end
    end while (bus.done !== 1'b1 && n < 20);
    check("latency", 32'(n - 1), 32'(WIDTH));
    @(negedge clk);
    check("busy_idle", 32'(bus.busy), 32'd0);
    last_out = e_out;
  endtask

  initial begin
    bus.start  = 1'b0;
    bus.data_a = '0;
    bus.data_b = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_out",  32'(bus.out),  32'd0);
    check("rst_acc",  32'(bus.acc),  32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);

    run_op(4'b0011, 4'b0001, 4'b0010, 1'b0, 5'b00010, 1'b0);
    run_op(4'b0001, 4'b0011, 4'b1110, 1'b1, 5'b11110, 1'b0);
    run_op(4'b1111, 4'b1111, 4'b0000, 1'b0, 5'b00000, 1'b0);
    run_op(4'b0000, 4'b1111, 4'b0001, 1'b1, 5'b10001, 1'b0);

    // Start re-asserted through SHIFT and DONE must be ignored.
    @(negedge clk);
    bus.start  = 1'b1;
    bus.data_a = 4'b0101;
    bus.data_b = 4'b0010;
    q.push_back('{out: 4'b0011, bout: 1'b0, acc: 5'b00011, ovf: 1'b0});
    @(negedge clk);
    bus.data_a = 4'b0000;
    bus.data_b = 4'b0001;
    repeat (WIDTH + 1) @(negedge clk);
    bus.start = 1'b0;
    check("busy_after_ignored", 32'(bus.busy), 32'd0);
    check("out_after_ignored",  32'(bus.out),  32'b0011);
    repeat (WIDTH + 2) @(negedge clk);
    check("no_second_done_busy", 32'(bus.busy), 32'd0);

    // Reset on the second SHIFT edge discards the operation.
    @(negedge clk);
    bus.start  = 1'b1;
    bus.data_a = 4'b0110;
    bus.data_b = 4'b0001;
    @(negedge clk);
    bus.start = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mid_rst_out",  32'(bus.out),  32'd0);
    check("mid_rst_bout", 32'(bus.bout), 32'd0);
    check("mid_rst_acc",  32'(bus.acc),  32'd0);
    check("mid_rst_ovf",  32'(bus.ovf),  32'd0);
    check("mid_rst_busy", 32'(bus.busy), 32'd0);
    repeat (WIDTH + 2) @(negedge clk);
    last_out = '0;

    run_op(4'b1000, 4'b0001, 4'b0111, 1'b0, 5'b00111, 1'b1);
    run_op(4'b0111, 4'b1000, 4'b1111, 1'b1, 5'b11111, 1'b1);
    run_op(4'b0011, 4'b0001, 4'b0010, 1'b0, 5'b00010, 1'b0);
    run_op(4'b1010, 4'b0101, 4'b0101, 1'b0, 5'b00101, 1'b1);

    repeat (3) @(negedge clk);
    check("scoreboard_empty", 32'(q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

`default_nettype wire
